// File: rtl/ring_cadence_gen.sv
// Cadenced buzzer/vibration drive from level-type ringer/motor requests.
// Define RING_CADENCE_TIMEOUT_EN to compile in the burst-count timeout (DONE state, muted).
module ring_cadence_gen #(
  parameter int unsigned TONE_DIV   = 4,
  parameter int unsigned ON_CYCLES  = 64,
  parameter int unsigned OFF_CYCLES = 32,
  parameter int unsigned MAX_BURSTS = 8
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       ringer,
  input  logic       motor,
  output logic       buzzer,
  output logic       vib,
  output logic       active,
  output logic       muted,
  output logic [7:0] burst_cnt
);

  localparam int unsigned PHASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned PW        = $clog2(PHASE_MAX) + 1;
  localparam int unsigned TW        = $clog2(TONE_DIV) + 1;

  localparam logic [PW-1:0] ON_LAST   = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  if (TONE_DIV < 1 || ON_CYCLES < 2 || OFF_CYCLES < 1 ||
      MAX_BURSTS < 1 || MAX_BURSTS > 255) begin : g_bad_params
    $error("ring_cadence_gen: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
`ifdef RING_CADENCE_TIMEOUT_EN
    , ST_DONE
`endif
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [TW-1:0] tone;
  logic          mode_ringer_r;
  logic          mode_motor_r;
  logic [7:0]    next_cnt;
  logic          req;

  assign req = ringer | motor;

  always_comb begin
    next_cnt = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
  end

`ifndef RING_CADENCE_TIMEOUT_EN
  assign muted = 1'b0;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      phase         <= '0;
      tone          <= '0;
      mode_ringer_r <= 1'b0;
      mode_motor_r  <= 1'b0;
      buzzer        <= 1'b0;
      vib           <= 1'b0;
      active        <= 1'b0;
      burst_cnt     <= '0;
`ifdef RING_CADENCE_TIMEOUT_EN
      muted         <= 1'b0;
`endif
    end else if (!req) begin
      // Withdrawing both requests aborts from any state; burst_cnt is kept.
      state  <= ST_IDLE;
      phase  <= '0;
      tone   <= '0;
      buzzer <= 1'b0;
      vib    <= 1'b0;
      active <= 1'b0;
`ifdef RING_CADENCE_TIMEOUT_EN
      muted  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state         <= ST_ON;
          mode_ringer_r <= ringer;
          mode_motor_r  <= motor;
          burst_cnt     <= '0;
          phase         <= '0;
          tone          <= '0;
          buzzer        <= ringer;
          vib           <= motor;
          active        <= 1'b1;
        end
        ST_ON: begin
          if (phase == ON_LAST) begin
            burst_cnt <= next_cnt;
            phase     <= '0;
            tone      <= '0;
            buzzer    <= 1'b0;
            vib       <= 1'b0;
`ifdef RING_CADENCE_TIMEOUT_EN
            if (next_cnt == 8'(MAX_BURSTS)) begin
              state  <= ST_DONE;
              active <= 1'b0;
              muted  <= 1'b1;
            end else begin
              state <= ST_OFF;
            end
`else
            state <= ST_OFF;
`endif
          end else begin
            phase <= phase + 1'b1;
            if (tone == TONE_LAST) begin
              tone   <= '0;
              buzzer <= mode_ringer_r & ~buzzer;
            end else begin
              tone <= tone + 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (phase == OFF_LAST) begin
            state         <= ST_ON;
            mode_ringer_r <= ringer;
            mode_motor_r  <= motor;
            phase         <= '0;
            tone          <= '0;
            buzzer        <= ringer;
            vib           <= motor;
          end else begin
            phase <= phase + 1'b1;
          end
        end
`ifdef RING_CADENCE_TIMEOUT_EN
        ST_DONE: begin
          state <= ST_DONE;
        end
`endif
        default: begin
          state  <= ST_IDLE;
          buzzer <= 1'b0;
          vib    <= 1'b0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_cadence_gen.sv
// Directed bench for ring_cadence_gen with TONE_DIV=2, ON=8, OFF=4, MAX_BURSTS=3.
// Timeout expectations follow RING_CADENCE_TIMEOUT_EN as compiled.
module tb_ring_cadence_gen;

  logic       clk = 1'b0;
  logic       areset;
  logic       ringer;
  logic       motor;
  logic       buzzer;
  logic       vib;
  logic       active;
  logic       muted;
  logic [7:0] burst_cnt;

  int checks = 0;
  int errors = 0;

  ring_cadence_gen #(
    .TONE_DIV  (2),
    .ON_CYCLES (8),
    .OFF_CYCLES(4),
    .MAX_BURSTS(3)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .ringer   (ringer),
    .motor    (motor),
    .buzzer   (buzzer),
    .vib      (vib),
    .active   (active),
    .muted    (muted),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  typedef struct {
    logic        r;
    logic        m;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pack(logic b, logic v, logic a, logic mu, int bc);
    return {b, v, a, mu, 8'(bc)};
  endfunction

  // Steady cadence from a fresh start at edge 0: ON 8, OFF 4, tone period 4.
  function automatic logic [11:0] cad_exp(int k, logic rmode, logic mmode);
    int  pos;
    logic on;
    pos = k % 12;
    on  = (pos < 8);
    return pack(on & rmode & (((pos / 2) % 2) == 0), on & mmode, 1'b1, 1'b0,
                k / 12 + (on ? 0 : 1));
  endfunction

  task automatic add(logic r, logic m, logic b, logic v, logic a, int bc);
    vec_t x;
    x.r   = r;
    x.m   = m;
    x.exp = pack(b, v, a, 1'b0, bc);
    vecs.push_back(x);
  endtask

  task automatic check(string name, int idx, logic [11:0] exp);
    logic [11:0] got;
    got = {buzzer, vib, active, muted, burst_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got b/v/a/m/cnt=%b exp %b", name, idx, got, exp);
    end
  endtask

  task automatic step(logic r, logic m);
    @(negedge clk);
    ringer = r;
    motor  = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic bpat[8];
    bpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Ring mode, then abort mid second burst.
    for (int i = 0; i < 8; i++) add(1, 0, bpat[i], 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 0, bpat[i], 0, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    // Vibrate mode; release lands on the OFF expiry edge.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    // Both requests, motor dropped mid burst: latched mode holds until next ON.
    for (int i = 0; i < 3; i++) add(1, 1, bpat[i], 1, 1, 0);
    for (int i = 3; i < 8; i++) add(1, 0, bpat[i], 1, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) add(1, 0, bpat[i], 0, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1);

    areset = 1'b1;
    ringer = 1'b0;
    motor  = 1'b0;
    #1;
    check("reset_state", 0, 12'h000);
    @(negedge clk);
    areset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].m);
      check("table", i, vecs[i].exp);
    end

    // Abort at the 5th cycle of the second ON burst, then restart fresh.
    for (int k = 0; k < 17; k++) begin
      step(1, 0);
      check("abort_run", k, cad_exp(k, 1'b1, 1'b0));
    end
    step(0, 0);
    check("abort_drop", 0, pack(0, 0, 0, 0, 1));
    for (int k = 0; k < 9; k++) begin
      step(1, 0);
      check("restart", k, cad_exp(k, 1'b1, 1'b0));
    end
    step(0, 0);
    check("restart_drop", 0, pack(0, 0, 0, 0, 1));

    // Asynchronous reset between edges during ON.
    for (int k = 0; k < 3; k++) begin
      step(1, 0);
      check("pre_reset", k, cad_exp(k, 1'b1, 1'b0));
    end
    #3;
    areset = 1'b1;
    #1;
    check("reset_async", 0, 12'h000);
    @(posedge clk);
    #1;
    check("reset_held", 0, 12'h000);
    @(negedge clk);
    areset = 1'b0;
    #1;
    check("reset_release", 0, 12'h000);
    @(posedge clk);
    #1;
    check("reset_restart", 0, pack(1, 0, 1, 0, 0));
    step(0, 0);
    check("reset_drop", 0, pack(0, 0, 0, 0, 0));

`ifdef RING_CADENCE_TIMEOUT_EN
    for (int k = 0; k < 60; k++) begin
      step(0, 1);
      if (k < 32) check("timeout_run", k, cad_exp(k, 1'b0, 1'b1));
      else        check("timeout_done", k, pack(0, 0, 0, 1, 3));
    end
    step(0, 0);
    check("timeout_release", 0, pack(0, 0, 0, 0, 3));
`else
    for (int k = 0; k < 100; k++) begin
      step(0, 1);
      check("cadence_run", k, cad_exp(k, 1'b0, 1'b1));
    end
    step(0, 0);
    check("cadence_release", 0, pack(0, 0, 0, 0, 8));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_cadence_gen.md
# ring_cadence_gen

Downstream stage of the ringer/motor select logic. It takes the level-type `ringer` and `motor` requests and turns them into cadenced drive signals. The buzzer gets a square-wave tone during ON bursts and the vibration motor is driven during the same bursts, with silent OFF gaps between bursts. An optional burst-count timeout mutes the alert until the request is withdrawn.

## Interface
Parameters:
- `TONE_DIV`, default 4: half-period of buzzer tone in clk cycles (≥1).
- `ON_CYCLES`, default 64: length of each ON burst in clk cycles (≥2).
- `OFF_CYCLES`, default 32: length of each OFF gap in clk cycles (≥1).
- `MAX_BURSTS`, default 8: burst limit before timeout (≥1, ≤255).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `areset`, input, 1: reset, asynchronous, active-high.
- `ringer`, input, 1: request audible alert (from upstream ringer select).
- `motor`, input, 1: request vibration alert (from upstream motor select).
- `buzzer`, output, 1: tone drive to speaker.
- `vib`, output, 1: vibration motor drive.
- `active`, output, 1: high in ON or OFF state.
- `muted`, output, 1: high in DONE state.
- `burst_cnt`, output, 8: number of completed ON bursts in current alert.

## Operation
- `req = ringer | motor`. The mode (`ringer`, `motor`) is latched into `mode_r` on every entry to ON.
- States are IDLE, ON, OFF and DONE. All outputs and state are registered.
- IDLE:
  - On `req=1` at a rising edge, go to ON.
  - Latch the mode, clear `burst_cnt`, load the phase counter.
- ON:
  - `vib = mode_r.motor`.
  - `buzzer` starts at `mode_r.ringer` on entry and toggles every `TONE_DIV` cycles while `mode_r.ringer` is set; otherwise it stays 0.
  - After exactly `ON_CYCLES` cycles, `burst_cnt` increments (saturates at 255).
  - Then go to DONE if the timeout is enabled and the new count equals `MAX_BURSTS`; otherwise go to OFF.
- OFF:
  - `buzzer = 0` and `vib = 0`.
  - After exactly `OFF_CYCLES` cycles, go to ON and relatch the mode.
- DONE:
  - `buzzer = 0`, `vib = 0`, `muted = 1`.
  - Stay in DONE while `req = 1`.
- `req = 0` sampled in any state forces IDLE at that edge. The drive outputs drop to 0 and `muted` clears.
- `burst_cnt` holds its last value in IDLE until the next alert starts.
- A mode change mid-burst has no effect until the next ON entry. Dropping both requests is the only way to abort.
- Both `ringer` and `motor` high together: buzzer and vib both drive. No priority applies.

## Timing
- Reset values: state IDLE, `buzzer=0`, `vib=0`, `active=0`, `muted=0`, `burst_cnt=0`, all counters 0. Reset takes effect immediately, independent of `clk`, including mid-burst.
- Start latency: if `req` is first sampled high at edge N, then `active`, `vib` and the first buzzer high all appear after edge N.
- ON occupies edges N..N+`ON_CYCLES`−1 exactly. The buzzer toggles after edges N+`TONE_DIV`, N+2·`TONE_DIV`, and so on.
- ON→OFF, OFF→ON and ON→DONE transitions have zero dead cycles.
- Stop latency: if `req` is sampled low at edge M, all outputs are 0 after edge M.
- If `req` drops on the same edge a phase would expire, IDLE wins.

## Configuration
- `RING_CADENCE_TIMEOUT_EN` defined:
  - The ON→DONE transition at `MAX_BURSTS` is compiled in.
  - `muted` functions as described.
- Not defined:
  - The DONE state and its logic are removed, and `muted` is tied to 0.
  - Cadence repeats ON/OFF indefinitely while `req=1`.
  - `burst_cnt` still counts and saturates at 255.

## Test plan
Parameters for all scenarios: `TONE_DIV=2`, `ON_CYCLES=8`, `OFF_CYCLES=4`, `MAX_BURSTS=3`, macro defined unless noted.
- Ring mode: `ringer=1`, `motor=0` held.
  - Expect `buzzer` 1,1,0,0,1,1,0,0 over the first ON burst, then 4 cycles of 0.
  - `vib=0` throughout.
- Vibrate mode: `motor=1` held.
  - Expect `vib` high 8 cycles, low 4, repeating.
  - `buzzer=0`, `active=1` from the cycle after the request.
- Timeout: `motor=1` held for 60 cycles.
  - After the 3rd burst (cycle 32), expect `muted=1`, `burst_cnt=3` and `vib=0` until release.
  - Release leads to IDLE and `muted=0` next edge.
- Abort and restart: drop `ringer` at cycle 5 of ON, so all outputs are 0 next edge.
  - Reassert it; a fresh ON of 8 cycles follows with `burst_cnt` cleared to 0.
- Reset mid-burst: assert `areset` asynchronously between edges in ON.
  - Outputs go to 0 immediately.
  - After release, with `req` held, ON begins the cycle after the first sampling edge.
- Macro undefined: `motor=1` held for 100 cycles.
  - Expect continuous 8/4 cadence, `muted=0`, `burst_cnt=8` at cycle 96.
